// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: handshake bundle between the requesters, the shared
// resource and mem_port_arbiter.
//   req   - per-requester request bits (requesters 0..3)
//   done  - completion of the current transaction from the shared resource
//   gnt   - one-hot grant, zero when nobody is granted
//   sel   - binary index of the granted requester (4:1 data mux select)
//   start - one-cycle pulse on the first cycle of a granted transaction
//   busy  - high while a transaction is in progress
//   err   - one-cycle pulse when a transaction is aborted on timeout
// modport master is the arbiter's view; modport slave is the client side.
interface mem_port_arbiter_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       start;
    logic       busy;
    logic       err;

    modport master (
        input  req,
        input  done,
        output gnt,
        output sel,
        output start,
        output busy,
        output err
    );

    modport slave (
        output req,
        output done,
        input  gnt,
        input  sel,
        input  start,
        input  busy,
        input  err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter granting one of four requesters
// access to a shared resource, one transaction at a time.
//   Clk - single clock, rising-edge active
//   Rst - asynchronous active-high reset
//   bus - mem_port_arbiter_if.master (req/done in, gnt/sel/start/busy/err out)
// Parameter TIMEOUT (1..255): maximum number of BUSY cycles spent waiting
// for done before the transaction is aborted with an err pulse.
// All outputs are registered.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                       Clk,
    input  logic                       Rst,
    mem_port_arbiter_if.master         bus
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    // Counter holds the number of done-low BUSY cycles already elapsed; the
    // abort fires on the edge that would make it reach TIMEOUT.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic       start_q, start_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] last_q, last_d;

    logic [1:0] win;
    logic [1:0] idx;
    logic       found;

    // Search upward from last+1; the fourth probe wraps back onto last itself
    // so a lone requester is re-granted.
    always_comb begin
        win   = last_q;
        idx   = last_q;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!found && bus.req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        start_d = 1'b0;
        busy_d  = busy_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            StIdle: begin
                // done is ignored here; req is only sampled in this state.
                if (found) begin
                    state_d = StBusy;
                    gnt_d   = 4'b0001 << win;
                    sel_d   = win;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = 8'd0;
                    last_d  = win;
                end else begin
                    gnt_d  = 4'b0000;
                    busy_d = 1'b0;
                end
            end
            StBusy: begin
                // done wins over a simultaneous timeout.
                if (bus.done) begin
                    state_d = StIdle;
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                    cnt_d   = 8'd0;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StIdle;
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= StIdle;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
            last_q  <= 2'd3;  // requester 0 gets first priority
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.start = start_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter built with
// TIMEOUT = 4. Inputs change and outputs are sampled 1 time unit after each
// rising clock edge.
module tb_mem_port_arbiter;

    logic Clk;
    logic Rst;
    int   tests;
    int   fails;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .TIMEOUT (4)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.master)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic st, input logic b, input logic e);
        logic [8:0] obs;
        logic [8:0] exp;
        obs = {bus.gnt, bus.sel, bus.start, bus.busy, bus.err};
        exp = {g, s, st, b, e};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed gnt=%b sel=%b start=%b busy=%b err=%b, expected gnt=%b sel=%b start=%b busy=%b err=%b",
                   tag, obs[8:5], obs[4:3], obs[2], obs[1], obs[0],
                   exp[8:5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        logic [3:0] rr_gnt [5];
        logic [1:0] rr_sel [5];

        rr_gnt[0] = 4'b0001; rr_sel[0] = 2'b00;
        rr_gnt[1] = 4'b0010; rr_sel[1] = 2'b01;
        rr_gnt[2] = 4'b0100; rr_sel[2] = 2'b10;
        rr_gnt[3] = 4'b1000; rr_sel[3] = 2'b11;
        rr_gnt[4] = 4'b0001; rr_sel[4] = 2'b00;

        tests    = 0;
        fails    = 0;
        Rst      = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        #1 Rst = 1'b1;
        #1 check("reset", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        Rst = 1'b0;

        // Round robin with all four requesting, done one cycle after start.
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_start", rr_gnt[i], rr_sel[i], 1'b1, 1'b1, 1'b0);
            tick();
            check("rr_hold", rr_gnt[i], rr_sel[i], 1'b0, 1'b1, 1'b0);
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            check("rr_idle", 4'b0000, rr_sel[i], 1'b0, 1'b0, 1'b0);
        end
        bus.req = 4'b0000;
        tick();
        check("idle_noreq", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);

        // Requester 2 alone, done three cycles after start: busy for 4 cycles.
        bus.req = 4'b0100;
        tick();
        check("r2_start", 4'b0100, 2'b10, 1'b1, 1'b1, 1'b0);
        tick();
        check("r2_busy1", 4'b0100, 2'b10, 1'b0, 1'b1, 1'b0);
        tick();
        check("r2_busy2", 4'b0100, 2'b10, 1'b0, 1'b1, 1'b0);
        tick();
        check("r2_busy3", 4'b0100, 2'b10, 1'b0, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        check("r2_done", 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0);

        // done in IDLE has no effect.
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("idle_done", 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0);

        // Timeout: requester 0, done never comes; req from 3 raised only in BUSY.
        bus.req = 4'b0001;
        tick();
        bus.req = 4'b0000;
        check("to_start", 4'b0001, 2'b00, 1'b1, 1'b1, 1'b0);
        tick();
        bus.req = 4'b1000;
        check("to_busy1", 4'b0001, 2'b00, 1'b0, 1'b1, 1'b0);
        tick();
        check("to_busy2", 4'b0001, 2'b00, 1'b0, 1'b1, 1'b0);
        tick();
        bus.req = 4'b0000;
        check("to_busy3", 4'b0001, 2'b00, 1'b0, 1'b1, 1'b0);
        tick();
        check("to_abort", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1);
        tick();
        check("to_after", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);

        // done on the same cycle the counter hits TIMEOUT: clean completion.
        bus.req = 4'b0010;
        tick();
        bus.req = 4'b0000;
        check("edge_start", 4'b0010, 2'b01, 1'b1, 1'b1, 1'b0);
        tick();
        check("edge_busy1", 4'b0010, 2'b01, 1'b0, 1'b1, 1'b0);
        tick();
        check("edge_busy2", 4'b0010, 2'b01, 1'b0, 1'b1, 1'b0);
        tick();
        check("edge_busy3", 4'b0010, 2'b01, 1'b0, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("edge_done", 4'b0000, 2'b01, 1'b0, 1'b0, 1'b0);
        tick();
        check("edge_after", 4'b0000, 2'b01, 1'b0, 1'b0, 1'b0);

        // Requester 2 drops req mid-BUSY; grant holds until done.
        bus.req = 4'b0100;
        tick();
        bus.req = 4'b0000;
        check("drop_start", 4'b0100, 2'b10, 1'b1, 1'b1, 1'b0);
        tick();
        check("drop_busy1", 4'b0100, 2'b10, 1'b0, 1'b1, 1'b0);
        tick();
        check("drop_busy2", 4'b0100, 2'b10, 1'b0, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("drop_done", 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0);

        // Lone continuous requester is re-granted after one IDLE cycle.
        bus.req = 4'b0001;
        tick();
        check("solo_g1", 4'b0001, 2'b00, 1'b1, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("solo_idle", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        bus.req = 4'b0000;
        check("solo_g2", 4'b0001, 2'b00, 1'b1, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("solo_done", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);

        // Reset mid-BUSY on requester 3, then 3 and 0 request: 0 wins.
        bus.req = 4'b1000;
        tick();
        bus.req = 4'b0000;
        check("rst_start", 4'b1000, 2'b11, 1'b1, 1'b1, 1'b0);
        tick();
        check("rst_busy", 4'b1000, 2'b11, 1'b0, 1'b1, 1'b0);
        #2 Rst = 1'b1;
        #1 check("rst_async", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        check("rst_held", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
        Rst     = 1'b0;
        bus.req = 4'b1001;
        tick();
        bus.req = 4'b0000;
        check("rst_regrant", 4'b0001, 2'b00, 1'b1, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("rst_done", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
